// File: rtl/srio_rx_pkg.sv
// Shared types and defaults for the SRIO/UDP receive path: FSM states,
// key-table entry layout and the byte-offset shift.
package srio_rx_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_LEN_WIDTH  = 10;
  localparam int DEF_SEQ_WIDTH  = 3;
  localparam int DEF_HDR_WORDS  = 32;
  localparam int DEF_KEY_NUM    = 4;
  localparam int DEF_KEY_WIDTH  = DEF_DATA_WIDTH / 2;

  // Word index to byte offset (8-byte words)
  localparam int ADDR_SHIFT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic                     vld;
    logic [DEF_KEY_WIDTH-1:0] key;
  } key_entry_t;

endpackage

// File: rtl/hash_match_engine_if.sv
// Stream, key-programming and match-result signals of hash_match_engine.
// master = stream source / consumer side, slave = the engine.
interface hash_match_engine_if #(
  parameter int DATA_WIDTH = srio_rx_pkg::DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = srio_rx_pkg::DEF_LEN_WIDTH,
  parameter int SEQ_WIDTH  = srio_rx_pkg::DEF_SEQ_WIDTH,
  parameter int KEY_NUM    = srio_rx_pkg::DEF_KEY_NUM,
  parameter int KEY_WIDTH  = srio_rx_pkg::DEF_KEY_WIDTH
);

  logic [DATA_WIDTH-1:0]      data_in;
  logic                       data_valid_in;
  logic [LEN_WIDTH-1:0]       data_length_in;
  logic                       key_wr_en_in;
  logic [$clog2(KEY_NUM)-1:0] key_wr_idx_in;
  logic [KEY_WIDTH-1:0]       key_wr_data_in;
  logic                       key_wr_vld_in;

  logic [SEQ_WIDTH-1:0]       pack_seq_out;
  logic [SEQ_WIDTH-1:0]       hash_pack_seq_out;
  logic                       hash_hit_out;
  logic [LEN_WIDTH-1:0]       hash_addr_offset_out;
  logic [$clog2(KEY_NUM)-1:0] hash_match_idx_out;
  logic                       pack_done_out;
  logic                       len_err_out;

  modport master (
    output data_in, data_valid_in, data_length_in,
    output key_wr_en_in, key_wr_idx_in, key_wr_data_in, key_wr_vld_in,
    input  pack_seq_out, hash_pack_seq_out, hash_hit_out,
    input  hash_addr_offset_out, hash_match_idx_out, pack_done_out, len_err_out
  );

  modport slave (
    input  data_in, data_valid_in, data_length_in,
    input  key_wr_en_in, key_wr_idx_in, key_wr_data_in, key_wr_vld_in,
    output pack_seq_out, hash_pack_seq_out, hash_hit_out,
    output hash_addr_offset_out, hash_match_idx_out, pack_done_out, len_err_out
  );

endinterface

// File: rtl/hash_match_engine_key_table.sv
// Programmable key table: registered entries, parallel compare and a
// lowest-index priority encoder; match/idx are combinational.
module hash_key_table
  import srio_rx_pkg::*;
#(
  parameter int KEY_NUM = DEF_KEY_NUM,
  parameter int IDX_W   = $clog2(KEY_NUM)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [DEF_KEY_WIDTH-1:0] wr_data,
  input  logic                     wr_vld,
  input  logic [DEF_KEY_WIDTH-1:0] key,
  output logic                     match,
  output logic [IDX_W-1:0]         idx
);

  key_entry_t           entries [KEY_NUM];
  logic [KEY_NUM-1:0]   hits;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < KEY_NUM; i++) begin
        entries[i] <= '0;
      end
    end else if (wr_en) begin
      entries[wr_idx].vld <= wr_vld;
      entries[wr_idx].key <= wr_data;
    end
  end

  always_comb begin
    hits = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      hits[i] = entries[i].vld && (entries[i].key == key);
    end
  end

  // Scan downward so the lowest matching entry wins
  always_comb begin
    match = 1'b0;
    idx   = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (hits[i]) begin
        match = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/hash_match_engine.sv
// Numbers packets on the receive stream, skips the header window and flags
// body words whose folded key hits the key table, for ram_controller.
module hash_match_engine
  import srio_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int SEQ_WIDTH  = DEF_SEQ_WIDTH,
  parameter int HDR_WORDS  = DEF_HDR_WORDS,
  parameter int KEY_NUM    = DEF_KEY_NUM,
  parameter int KEY_WIDTH  = DEF_KEY_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  hash_match_engine_if.slave  bus
);

  localparam int IDX_W = $clog2(KEY_NUM);
  localparam logic [LEN_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [LEN_WIDTH-1:0] HDR_LAST  = LEN_WIDTH'(HDR_WORDS - 1);
  localparam logic [LEN_WIDTH-1:0] HDR_FIRST = LEN_WIDTH'(HDR_WORDS);

  state_t               state;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] len;
  logic [SEQ_WIDTH-1:0] seq;
  logic [SEQ_WIDTH-1:0] hash_seq;
  logic                 vld_p1;
  logic [LEN_WIDTH-1:0] offset_p1;
  logic [IDX_W-1:0]     idx_p1;

  logic [DATA_WIDTH-1:0] word;
  logic [KEY_WIDTH-1:0]  fold;
  logic                  start;
  logic                  in_body;
  logic                  done_now;
  logic [LEN_WIDTH-1:0]  cur;
  logic [LEN_WIDTH-1:0]  body_idx;
  logic                  match;
  logic [IDX_W-1:0]      match_idx;

  assign word     = bus.data_in;
  assign fold     = word[DATA_WIDTH-1:KEY_WIDTH] ^ word[KEY_WIDTH-1:0];
  assign start    = bus.data_valid_in && (state == IDLE || state == DONE);
  assign cur      = start ? '0 : cnt;
  assign in_body  = bus.data_valid_in && (state == BODY);
  assign body_idx = cur - HDR_FIRST;
  // Packet end is the first idle cycle after the run, so a hit on the last
  // body word lines up with the done pulse.
  assign done_now = (state == HDR || state == BODY) && !bus.data_valid_in;

  hash_key_table #(
    .KEY_NUM (KEY_NUM)
  ) u_key_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.key_wr_en_in),
    .wr_idx  (bus.key_wr_idx_in),
    .wr_data (bus.key_wr_data_in),
    .wr_vld  (bus.key_wr_vld_in),
    .key     (fold),
    .match   (match),
    .idx     (match_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      len       <= '0;
      seq       <= '0;
      hash_seq  <= '0;
      vld_p1    <= 1'b0;
      offset_p1 <= '0;
      idx_p1    <= '0;
    end else begin
      // Stage p1: registered match result
      vld_p1 <= in_body && match;
      if (in_body && match) begin
        offset_p1 <= body_idx << ADDR_SHIFT;
        idx_p1    <= match_idx;
      end

      if (bus.data_valid_in) begin
        cnt <= start ? LEN_WIDTH'(1) : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
        len <= bus.data_length_in;
      end

      if (in_body && cur == HDR_FIRST) begin
        hash_seq <= seq;
      end

      if (done_now) begin
        seq <= seq + 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (bus.data_valid_in) begin
            state <= (cur == HDR_LAST) ? BODY : HDR;
          end else begin
            state <= IDLE;
          end
        end
        HDR: begin
          if (!bus.data_valid_in) begin
            state <= DONE;
          end else if (cur == HDR_LAST) begin
            state <= BODY;
          end
        end
        BODY: begin
          if (!bus.data_valid_in) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pack_seq_out         = seq;
  assign bus.hash_pack_seq_out    = hash_seq;
  assign bus.hash_hit_out         = vld_p1;
  assign bus.hash_addr_offset_out = offset_p1;
  assign bus.hash_match_idx_out   = idx_p1;
  assign bus.pack_done_out        = done_now;
  assign bus.len_err_out          = done_now && (cnt != len);

endmodule

// File: tb/tb_hash_match_engine.sv
// Scoreboard bench for hash_match_engine: a reference model of the key
// table and packet numbering predicts every hit and every packet end.
module tb_hash_match_engine;
  import srio_rx_pkg::*;

  localparam int HDR = DEF_HDR_WORDS;

  typedef struct {int off; int idx; int seq;} hit_t;
  typedef struct {bit err; int seq;} done_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hash_match_engine_if bus ();

  hash_match_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  hit_t        hit_q[$];
  done_t       done_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  int          n_err    = 0;
  logic [31:0] mkey[4];
  bit          mvld[4];
  int          mseq  = 0;
  int          mhseq = 0;

  function automatic void model_word(input int k);
    if (k == HDR) mhseq = mseq;
    if (k >= HDR) begin
      for (int i = 0; i < 4; i++) begin
        if (mvld[i] && mkey[i] == 32'(k + 1)) begin
          hit_q.push_back('{off: ((k - HDR) * 8) % 1024, idx: i, seq: mhseq});
          break;
        end
      end
    end
  endfunction

  // Sample at the falling edge, then return at posedge+1 ready to drive
  task automatic advance();
    hit_t  eh;
    done_t ed;
    @(negedge clk);
    if (bus.hash_hit_out === 1'b1) begin
      n_checks++;
      if (hit_q.size() == 0) begin
        n_fail++;
        $display("FAIL hit_unexpected: got off=%0d idx=%0d, required no hit",
                 bus.hash_addr_offset_out, bus.hash_match_idx_out);
      end else begin
        eh = hit_q.pop_front();
        if (bus.hash_addr_offset_out !== 10'(eh.off) || bus.hash_match_idx_out !== 2'(eh.idx) ||
            bus.hash_pack_seq_out !== 3'(eh.seq)) begin
          n_fail++;
          $display("FAIL hit: got off=%0d idx=%0d seq=%0d, required off=%0d idx=%0d seq=%0d",
                   bus.hash_addr_offset_out, bus.hash_match_idx_out, bus.hash_pack_seq_out,
                   eh.off, eh.idx, eh.seq);
        end
      end
    end
    if (bus.pack_done_out === 1'b1) begin
      n_done++;
      if (bus.len_err_out === 1'b1) n_err++;
      n_checks++;
      if (done_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: got pack_done seq=%0d, required none", bus.pack_seq_out);
      end else begin
        ed = done_q.pop_front();
        if (bus.len_err_out !== ed.err || bus.pack_seq_out !== 3'(ed.seq)) begin
          n_fail++;
          $display("FAIL done: got len_err=%0b seq=%0d, required len_err=%0b seq=%0d",
                   bus.len_err_out, bus.pack_seq_out, ed.err, ed.seq);
        end
      end
    end else if (bus.len_err_out !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL len_err_alone: got len_err=%b, required 0 without pack_done", bus.len_err_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input int i, input logic [31:0] d, input bit v);
    bus.key_wr_en_in   = 1'b1;
    bus.key_wr_idx_in  = 2'(i);
    bus.key_wr_data_in = d;
    bus.key_wr_vld_in  = v;
    advance();
    bus.key_wr_en_in   = 1'b0;
    mkey[i] = d;
    mvld[i] = v;
  endtask

  task automatic send_packet(input int nwords, input int len, input int gap, input int wr_at,
                             input int wr_idx, input logic [31:0] wr_data, input bit wr_vld);
    for (int k = 0; k < nwords; k++) begin
      bus.key_wr_en_in   = 1'b0;
      bus.data_in        = {32'h0, 32'(k + 1)};
      bus.data_valid_in  = 1'b1;
      bus.data_length_in = 10'(len);
      model_word(k);
      if (k == wr_at) begin
        bus.key_wr_en_in   = 1'b1;
        bus.key_wr_idx_in  = 2'(wr_idx);
        bus.key_wr_data_in = wr_data;
        bus.key_wr_vld_in  = wr_vld;
        mkey[wr_idx] = wr_data;
        mvld[wr_idx] = wr_vld;
      end
      advance();
    end
    bus.key_wr_en_in  = 1'b0;
    bus.data_valid_in = 1'b0;
    bus.data_in       = '0;
    done_q.push_back('{err: (nwords != len), seq: mseq});
    mseq = (mseq + 1) % 8;
    advance();
    repeat (gap) advance();
  endtask

  task automatic send(input int nwords, input int len);
    send_packet(nwords, len, 5, -1, 0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    n_checks++; if (bus.pack_seq_out !== 3'd0) begin n_fail++; $display("FAIL rst_pack_seq: got %0d, required 0", bus.pack_seq_out); end
    n_checks++; if (bus.hash_pack_seq_out !== 3'd0) begin n_fail++; $display("FAIL rst_hash_seq: got %0d, required 0", bus.hash_pack_seq_out); end
    n_checks++; if (bus.hash_hit_out !== 1'b0) begin n_fail++; $display("FAIL rst_hit: got %b, required 0", bus.hash_hit_out); end
    n_checks++; if (bus.hash_addr_offset_out !== 10'd0) begin n_fail++; $display("FAIL rst_offset: got %0d, required 0", bus.hash_addr_offset_out); end
    n_checks++; if (bus.hash_match_idx_out !== 2'd0) begin n_fail++; $display("FAIL rst_idx: got %0d, required 0", bus.hash_match_idx_out); end
    n_checks++; if (bus.pack_done_out !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", bus.pack_done_out); end
    n_checks++; if (bus.len_err_out !== 1'b0) begin n_fail++; $display("FAIL rst_len_err: got %b, required 0", bus.len_err_out); end
  endtask

  task automatic test_single_key();
    write_key(0, 32'h1, 1'b1);
    send(48, 48);
    write_key(0, 32'h24, 1'b1);
    send(48, 48);
    n_checks++; if (bus.hash_addr_offset_out !== 10'd24 || bus.hash_match_idx_out !== 2'd0) begin
      n_fail++; $display("FAIL single_hold: got off=%0d idx=%0d, required off=24 idx=0", bus.hash_addr_offset_out, bus.hash_match_idx_out); end
    n_checks++; if (hit_q.size() + done_q.size() != 0) begin
      n_fail++; $display("FAIL single_drain: got %0d pending, required 0", hit_q.size() + done_q.size()); end
  endtask

  task automatic test_multi_key();
    write_key(1, 32'h27, 1'b1);
    write_key(2, 32'h30, 1'b1);
    send(48, 48);
    n_checks++; if (bus.hash_addr_offset_out !== 10'd120 || bus.hash_match_idx_out !== 2'd2) begin
      n_fail++; $display("FAIL multi_hold: got off=%0d idx=%0d, required off=120 idx=2", bus.hash_addr_offset_out, bus.hash_match_idx_out); end
    n_checks++; if (hit_q.size() + done_q.size() != 0) begin
      n_fail++; $display("FAIL multi_drain: got %0d pending, required 0", hit_q.size() + done_q.size()); end
  endtask

  task automatic test_priority();
    write_key(0, 32'h0, 1'b0);
    write_key(2, 32'h0, 1'b0);
    write_key(1, 32'h24, 1'b1);
    write_key(3, 32'h24, 1'b1);
    send(48, 48);
    n_checks++; if (bus.hash_match_idx_out !== 2'd1) begin n_fail++; $display("FAIL prio_lowest: got idx=%0d, required 1", bus.hash_match_idx_out); end
    send_packet(48, 48, 5, 35, 1, 32'h24, 1'b0);
    n_checks++; if (bus.hash_match_idx_out !== 2'd1) begin n_fail++; $display("FAIL prio_old_entry: got idx=%0d, required 1", bus.hash_match_idx_out); end
    send(48, 48);
    n_checks++; if (bus.hash_match_idx_out !== 2'd3) begin n_fail++; $display("FAIL prio_new_entry: got idx=%0d, required 3", bus.hash_match_idx_out); end
    n_checks++; if (hit_q.size() + done_q.size() != 0) begin
      n_fail++; $display("FAIL prio_drain: got %0d pending, required 0", hit_q.size() + done_q.size()); end
  endtask

  task automatic test_back_to_back();
    int done0 = n_done;
    int err0  = n_err;
    for (int i = 0; i < 16; i++) send(48 + i, 48 + i);
    n_checks++; if (n_done - done0 != 16) begin n_fail++; $display("FAIL b2b_done_count: got %0d, required 16", n_done - done0); end
    n_checks++; if (n_err != err0) begin n_fail++; $display("FAIL b2b_len_err: got %0d errors, required 0", n_err - err0); end
    n_checks++; if (bus.pack_seq_out !== 3'(mseq)) begin n_fail++; $display("FAIL b2b_seq: got %0d, required %0d", bus.pack_seq_out, mseq); end
    n_checks++; if (hit_q.size() + done_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: got %0d pending, required 0", hit_q.size() + done_q.size()); end
  endtask

  task automatic test_len_err();
    int err0 = n_err;
    send(40, 48);
    send(20, 20);
    n_checks++; if (n_err - err0 != 1) begin n_fail++; $display("FAIL len_err_count: got %0d, required 1", n_err - err0); end
    n_checks++; if (bus.hash_pack_seq_out !== 3'(mhseq)) begin n_fail++; $display("FAIL short_hash_seq: got %0d, required %0d", bus.hash_pack_seq_out, mhseq); end
    n_checks++; if (hit_q.size() + done_q.size() != 0) begin
      n_fail++; $display("FAIL len_drain: got %0d pending, required 0", hit_q.size() + done_q.size()); end
  endtask

  task automatic test_reset_mid();
    send(20, 20);
    for (int k = 0; k < 33; k++) begin
      bus.data_in = {32'h0, 32'(k + 1)}; bus.data_valid_in = 1'b1; bus.data_length_in = 10'd48;
      model_word(k);
      advance();
    end
    bus.data_in = {32'h0, 32'd34};
    #2 reset = 1'b0;
    #1;
    test_reset();
    bus.data_valid_in = 1'b0;
    hit_q.delete(); done_q.delete();
    mseq = 0; mhseq = 0;
    for (int i = 0; i < 4; i++) begin mkey[i] = '0; mvld[i] = 1'b0; end
    @(posedge clk); #1;
    reset = 1'b1;
    advance();
    write_key(0, 32'h24, 1'b1);
    send(48, 48);
    n_checks++; if (bus.hash_pack_seq_out !== 3'd0 || bus.hash_addr_offset_out !== 10'd24) begin
      n_fail++; $display("FAIL post_rst_hit: got seq=%0d off=%0d, required seq=0 off=24", bus.hash_pack_seq_out, bus.hash_addr_offset_out); end
    n_checks++; if (bus.pack_seq_out !== 3'd1) begin n_fail++; $display("FAIL post_rst_seq: got %0d, required 1", bus.pack_seq_out); end
    n_checks++; if (hit_q.size() + done_q.size() != 0) begin
      n_fail++; $display("FAIL post_rst_drain: got %0d pending, required 0", hit_q.size() + done_q.size()); end
  endtask

  initial begin
    reset = 1'b0;
    bus.data_in = '0; bus.data_valid_in = 1'b0; bus.data_length_in = '0;
    bus.key_wr_en_in = 1'b0; bus.key_wr_idx_in = '0; bus.key_wr_data_in = '0; bus.key_wr_vld_in = 1'b0;
    for (int i = 0; i < 4; i++) begin mkey[i] = '0; mvld[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    advance();
    test_single_key();
    test_multi_key();
    test_priority();
    test_back_to_back();
    test_len_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
